id_ex_pipe_reg: RTL and testbench

// - ID/EX pipeline register of the 5-stage MIPS core. Captures decoded controls, operands and register

---
 rtl/id_ex_pipe_reg.sv | 166 ++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded ID fields, inserts bubbles on stall/flush, freezes on hold.
// Optional ID_EX_PERF_EN adds saturating bubble/flush counters; otherwise the counter ports read 0.
module id_ex_pipe_reg #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              stall,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic [DATA_W-1:0] ID_PC4,
    input  logic [DATA_W-1:0] ID_RsData,
    input  logic [DATA_W-1:0] ID_RtData,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic [4:0]        ID_Rd,
    input  logic [4:0]        ID_Shamt,
    output logic [CTRL_W-1:0] EX_Ctrl,
    output logic [DATA_W-1:0] EX_PC4,
    output logic [DATA_W-1:0] EX_RsData,
    output logic [DATA_W-1:0] EX_RtData,
    output logic [DATA_W-1:0] EX_Imm,
    output logic [4:0]        EX_Rs,
    output logic [4:0]        EX_Rt,
    output logic [4:0]        EX_Rd,
    output logic [4:0]        EX_Shamt,
    output logic              EX_RegWrite,
    output logic              EX_MemRead,
    output logic              EX_MemWrite,
    output logic              EX_Valid,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] rsData_q, rsData_d;
    logic [DATA_W-1:0] rtData_q, rtData_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        rs_q, rs_d;
    logic [4:0]        rt_q, rt_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        shamt_q, shamt_d;
    logic              valid_q, valid_d;

    logic doFlush;
    logic doStall;

    // Hold outranks everything; a simultaneous flush+stall is treated purely as a flush.
    assign doFlush = !hold && flush;
    assign doStall = !hold && !flush && stall;

    always_comb begin
        ctrl_d   = ctrl_q;
        pc4_d    = pc4_q;
        rsData_d = rsData_q;
        rtData_d = rtData_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        shamt_d  = shamt_q;
        valid_d  = valid_q;
        if (doFlush || doStall) begin
            // All-zero bubble keeps EX_MemRead low so a load-use stall never repeats.
            ctrl_d   = '0;
            pc4_d    = '0;
            rsData_d = '0;
            rtData_d = '0;
            imm_d    = '0;
            rs_d     = '0;
            rt_d     = '0;
            rd_d     = '0;
            shamt_d  = '0;
            valid_d  = 1'b0;
        end else if (!hold) begin
            ctrl_d   = ID_Ctrl;
            pc4_d    = ID_PC4;
            rsData_d = ID_RsData;
            rtData_d = ID_RtData;
            imm_d    = ID_Imm;
            rs_d     = ID_Rs;
            rt_d     = ID_Rt;
            rd_d     = ID_Rd;
            shamt_d  = ID_Shamt;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            pc4_q    <= '0;
            rsData_q <= '0;
            rtData_q <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            shamt_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            pc4_q    <= pc4_d;
            rsData_q <= rsData_d;
            rtData_q <= rtData_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            shamt_q  <= shamt_d;
            valid_q  <= valid_d;
        end
    end

    assign EX_Ctrl     = ctrl_q;
    assign EX_PC4      = pc4_q;
    assign EX_RsData   = rsData_q;
    assign EX_RtData   = rtData_q;
    assign EX_Imm      = imm_q;
    assign EX_Rs       = rs_q;
    assign EX_Rt       = rt_q;
    assign EX_Rd       = rd_q;
    assign EX_Shamt    = shamt_q;
    assign EX_RegWrite = ctrl_q[0];
    assign EX_MemRead  = ctrl_q[1];
    assign EX_MemWrite = ctrl_q[2];
    assign EX_Valid    = valid_q;

`ifdef ID_EX_PERF_EN
    logic [31:0] bubbleCnt_q, bubbleCnt_d;
    logic [31:0] flushCnt_q, flushCnt_d;

    // Counters saturate instead of wrapping so a long run never reports a misleadingly small value.
    always_comb begin
        bubbleCnt_d = bubbleCnt_q;
        flushCnt_d  = flushCnt_q;
        if (doStall && (bubbleCnt_q != 32'hFFFF_FFFF)) begin
            bubbleCnt_d = bubbleCnt_q + 32'd1;
        end
        if (doFlush && (flushCnt_q != 32'hFFFF_FFFF)) begin
            flushCnt_d = flushCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubbleCnt_q <= '0;
            flushCnt_q  <= '0;
        end else begin
            bubbleCnt_q <= bubbleCnt_d;
            flushCnt_q  <= flushCnt_d;
        end
    end

    assign bubble_cnt = bubbleCnt_q;
    assign flush_cnt  = flushCnt_q;
`else
    assign bubble_cnt = 32'd0;
    assign flush_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed testbench for id_ex_pipe_reg: reset, load-use bubble, flush, hold, priority, async reset.
// Counter expectations follow ID_EX_PERF_EN (zero when the macro is undefined).
module tb_id_ex_pipe_reg;

    localparam int CTRL_W = 12;
    localparam int DATA_W = 32;
`ifdef ID_EX_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              hold;
    logic              flush;
    logic              stall;
    logic [CTRL_W-1:0] ID_Ctrl;
    logic [DATA_W-1:0] ID_PC4, ID_RsData, ID_RtData, ID_Imm;
    logic [4:0]        ID_Rs, ID_Rt, ID_Rd, ID_Shamt;
    logic [CTRL_W-1:0] EX_Ctrl;
    logic [DATA_W-1:0] EX_PC4, EX_RsData, EX_RtData, EX_Imm;
    logic [4:0]        EX_Rs, EX_Rt, EX_Rd, EX_Shamt;
    logic              EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Valid;
    logic [31:0]       bubble_cnt, flush_cnt;

    int checkCount = 0;
    int failCount  = 0;
    int expBubble  = 0;
    int expFlush   = 0;

    id_ex_pipe_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .stall(stall),
        .ID_Ctrl(ID_Ctrl), .ID_PC4(ID_PC4), .ID_RsData(ID_RsData), .ID_RtData(ID_RtData),
        .ID_Imm(ID_Imm), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rd(ID_Rd), .ID_Shamt(ID_Shamt),
        .EX_Ctrl(EX_Ctrl), .EX_PC4(EX_PC4), .EX_RsData(EX_RsData), .EX_RtData(EX_RtData),
        .EX_Imm(EX_Imm), .EX_Rs(EX_Rs), .EX_Rt(EX_Rt), .EX_Rd(EX_Rd), .EX_Shamt(EX_Shamt),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite),
        .EX_Valid(EX_Valid), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic setId(input logic [CTRL_W-1:0] ctrl, input logic [DATA_W-1:0] pc4,
                         input logic [DATA_W-1:0] rsData, input logic [DATA_W-1:0] rtData,
                         input logic [DATA_W-1:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] shamt);
        ID_Ctrl = ctrl; ID_PC4 = pc4; ID_RsData = rsData; ID_RtData = rtData;
        ID_Imm = imm; ID_Rs = rs; ID_Rt = rt; ID_Rd = rd; ID_Shamt = shamt;
    endtask

    // Advance to just after the next rising edge; both driving and sampling happen there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        hold = 1'b0; flush = 1'b0; stall = 1'b0;
        reset = 1'b1;
        setId(12'($urandom), $urandom, $urandom, $urandom, $urandom,
              5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        #1;
        checkCount++;
        if ({EX_Ctrl, EX_PC4, EX_RsData, EX_RtData, EX_Imm, EX_Rs, EX_Rt, EX_Rd, EX_Shamt,
             EX_RegWrite, EX_MemRead, EX_MemWrite, EX_Valid} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: EX_Ctrl=%h EX_PC4=%h EX_Rs=%0d EX_Valid=%b, required all 0",
                     EX_Ctrl, EX_PC4, EX_Rs, EX_Valid);
        end
        tick();
        checkCount++;
        if ({EX_Ctrl, EX_Rs, EX_Rt, EX_Rd, EX_Valid, bubble_cnt, flush_cnt} !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_held_edge: EX_Ctrl=%h EX_Rd=%0d EX_Valid=%b, required all 0",
                     EX_Ctrl, EX_Rd, EX_Valid);
        end
        @(negedge clk);
        reset = 1'b0;
        setId(12'h001, 32'h0000_0004, 32'h11, 32'h22, 32'h0, 5'd5, 5'd6, 5'd7, 5'd0);
        tick();
        checkCount++;
        if (EX_Rs !== 5'd5 || EX_Valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_release_capture: EX_Rs=%0d EX_Valid=%b, required 5 and 1", EX_Rs, EX_Valid);
        end
    endtask

    task automatic test_load_use();
        // lw $8, 0x10($29)
        setId(12'h003, 32'h0000_0100, 32'h0000_1000, 32'h0, 32'h10, 5'd29, 5'd8, 5'd0, 5'd0);
        tick();
        checkCount++;
        if (EX_MemRead !== 1'b1 || EX_Rt !== 5'd8 || EX_Valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL load_capture: MemRead=%b Rt=%0d Valid=%b, required 1 8 1", EX_MemRead, EX_Rt, EX_Valid);
        end
        // add $10, $8, $9 depends on the load
        stall = 1'b1;
        setId(12'h001, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0009, 32'h0, 5'd8, 5'd9, 5'd10, 5'd0);
        tick();
        expBubble++;
        checkCount++;
        if (EX_Ctrl !== '0 || EX_Rs !== 5'd0 || EX_Valid !== 1'b0 || EX_MemRead !== 1'b0 || EX_RsData !== '0) begin
            failCount++;
            $display("[TB] FAIL stall_bubble: Ctrl=%h Rs=%0d Valid=%b RsData=%h, required 0 0 0 0",
                     EX_Ctrl, EX_Rs, EX_Valid, EX_RsData);
        end
        checkCount++;
        if (bubble_cnt !== (PERF ? 32'(expBubble) : 32'd0) || flush_cnt !== (PERF ? 32'(expFlush) : 32'd0)) begin
            failCount++;
            $display("[TB] FAIL stall_counters: bubble=%0d flush=%0d, required %0d %0d",
                     bubble_cnt, flush_cnt, PERF ? expBubble : 0, PERF ? expFlush : 0);
        end
        stall = 1'b0;
        tick();
        checkCount++;
        if (EX_Rs !== 5'd8 || EX_Ctrl !== 12'h001 || EX_RsData !== 32'hDEAD_BEEF || EX_Valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL stall_release: Rs=%0d Ctrl=%h RsData=%h Valid=%b, required 8 001 deadbeef 1",
                     EX_Rs, EX_Ctrl, EX_RsData, EX_Valid);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        setId(12'hFFF, 32'h0000_0200, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd9, 5'd3);
        tick();
        expFlush++;
        checkCount++;
        if (EX_Ctrl !== '0 || EX_Rd !== 5'd0 || EX_Valid !== 1'b0 || EX_RegWrite !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL flush_bubble: Ctrl=%h Rd=%0d Valid=%b, required 0 0 0", EX_Ctrl, EX_Rd, EX_Valid);
        end
        checkCount++;
        if (flush_cnt !== (PERF ? 32'(expFlush) : 32'd0) || bubble_cnt !== (PERF ? 32'(expBubble) : 32'd0)) begin
            failCount++;
            $display("[TB] FAIL flush_counters: flush=%0d bubble=%0d, required %0d %0d",
                     flush_cnt, bubble_cnt, PERF ? expFlush : 0, PERF ? expBubble : 0);
        end
        flush = 1'b0;
    endtask

    task automatic test_hold();
        // add $3, $1, $2
        setId(12'h001, 32'h0000_0300, 32'h0000_0AAA, 32'h0000_0BBB, 32'h0, 5'd1, 5'd2, 5'd3, 5'd0);
        tick();
        checkCount++;
        if (EX_Rd !== 5'd3) begin
            failCount++;
            $display("[TB] FAIL hold_setup: Rd=%0d, required 3", EX_Rd);
        end
        hold = 1'b1; flush = 1'b1; stall = 1'b1;
        setId(12'hFFF, 32'h0000_0304, 32'h1, 32'h2, 32'h3, 5'd4, 5'd5, 5'd7, 5'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkCount++;
            if (EX_Rd !== 5'd3 || EX_Ctrl !== 12'h001 || EX_Valid !== 1'b1 || EX_RsData !== 32'h0000_0AAA) begin
                failCount++;
                $display("[TB] FAIL hold_keep[%0d]: Rd=%0d Ctrl=%h Valid=%b RsData=%h, required 3 001 1 00000aaa",
                         i, EX_Rd, EX_Ctrl, EX_Valid, EX_RsData);
            end
            checkCount++;
            if (bubble_cnt !== (PERF ? 32'(expBubble) : 32'd0) || flush_cnt !== (PERF ? 32'(expFlush) : 32'd0)) begin
                failCount++;
                $display("[TB] FAIL hold_counters[%0d]: bubble=%0d flush=%0d, required %0d %0d",
                         i, bubble_cnt, flush_cnt, PERF ? expBubble : 0, PERF ? expFlush : 0);
            end
        end
        // Deferred flush takes effect on the first edge after hold releases.
        hold = 1'b0;
        tick();
        expFlush++;
        checkCount++;
        if (EX_Ctrl !== '0 || EX_Rd !== 5'd0 || EX_Valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL hold_release_flush: Ctrl=%h Rd=%0d Valid=%b, required 0 0 0", EX_Ctrl, EX_Rd, EX_Valid);
        end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_priority();
        setId(12'h005, 32'h0000_0400, 32'h10, 32'h20, 32'h30, 5'd11, 5'd12, 5'd13, 5'd1);
        tick();
        flush = 1'b1; stall = 1'b1;
        tick();
        expFlush++;
        checkCount++;
        if (EX_Ctrl !== '0 || EX_Valid !== 1'b0 || EX_Rs !== 5'd0) begin
            failCount++;
            $display("[TB] FAIL priority_bubble: Ctrl=%h Valid=%b Rs=%0d, required 0 0 0", EX_Ctrl, EX_Valid, EX_Rs);
        end
        checkCount++;
        if (flush_cnt !== (PERF ? 32'(expFlush) : 32'd0) || bubble_cnt !== (PERF ? 32'(expBubble) : 32'd0)) begin
            failCount++;
            $display("[TB] FAIL priority_counters: flush=%0d bubble=%0d, required %0d %0d",
                     flush_cnt, bubble_cnt, PERF ? expFlush : 0, PERF ? expBubble : 0);
        end
        flush = 1'b0; stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0]  i6;
        logic [31:0] expWord;
        for (int i = 0; i < 4; i++) begin
            i6 = 6'(i);
            setId(12'h100 + 12'(i), 32'h0000_0500 + 32'(4 * i), 32'hA000_0000 + 32'(i),
                  32'hB000_0000 + 32'(i), 32'hC000_0000 + 32'(i),
                  5'(i6 + 6'd1), 5'(i6 + 6'd2), 5'(i6 + 6'd3), 5'(i6 + 6'd4));
            tick();
            expWord = 32'h0000_0500 + 32'(4 * i);
            checkCount++;
            if (EX_Ctrl !== 12'h100 + 12'(i) || EX_PC4 !== expWord || EX_RtData !== 32'hB000_0000 + 32'(i) ||
                EX_Imm !== 32'hC000_0000 + 32'(i) || EX_Rd !== 5'(i6 + 6'd3) || EX_Shamt !== 5'(i6 + 6'd4) ||
                EX_Valid !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL back_to_back[%0d]: Ctrl=%h PC4=%h Imm=%h Rd=%0d Shamt=%0d, required %h %h %h %0d %0d",
                         i, EX_Ctrl, EX_PC4, EX_Imm, EX_Rd, EX_Shamt, 12'h100 + 12'(i), expWord,
                         32'hC000_0000 + 32'(i), i + 3, i + 4);
            end
        end
    endtask

    task automatic test_async_reset();
        setId(12'h00F, 32'h0000_0600, 32'h77, 32'h88, 32'h99, 5'd20, 5'd21, 5'd22, 5'd23);
        tick();
        stall = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        expBubble = 0;
        expFlush  = 0;
        checkCount++;
        if ({EX_Ctrl, EX_PC4, EX_RsData, EX_RtData, EX_Imm, EX_Rs, EX_Rt, EX_Rd, EX_Shamt, EX_Valid,
             bubble_cnt, flush_cnt} !== '0) begin
            failCount++;
            $display("[TB] FAIL async_reset_clear: Ctrl=%h Rs=%0d Valid=%b bubble=%0d flush=%0d, required all 0",
                     EX_Ctrl, EX_Rs, EX_Valid, bubble_cnt, flush_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        expBubble++;
        checkCount++;
        if (EX_Valid !== 1'b0 || bubble_cnt !== (PERF ? 32'(expBubble) : 32'd0)) begin
            failCount++;
            $display("[TB] FAIL async_reset_resume_stall: Valid=%b bubble=%0d, required 0 %0d",
                     EX_Valid, bubble_cnt, PERF ? expBubble : 0);
        end
        stall = 1'b0;
        tick();
        checkCount++;
        if (EX_Rd !== 5'd22 || EX_Valid !== 1'b1 || EX_MemWrite !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL async_reset_resume_capture: Rd=%0d Valid=%b MemWrite=%b, required 22 1 1",
                     EX_Rd, EX_Valid, EX_MemWrite);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_flush();
        test_hold();
        test_priority();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
